// File: rtl/rsa_host_initiator.sv
// ---------------------------------------------------------------------------
// rsa_host_initiator
//
// Host-side sequencer for an en/eoc modular-exponentiation core. It collects
// four operand words from a valid/ready stream, in the order P, E, M, Const.
// It then holds them on the core's operand inputs and raises core_en until
// the core signals eoc. The captured result C is returned over a valid/ready
// result stream. A watchdog aborts a run that takes too long and reports the
// abort through out_err.
//
// Parameters
//   WIDTH           operand/result word width (must match the core)
//   TIMEOUT_CYCLES  maximum number of cycles spent running before abort (>= 1)
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    operand stream (P, E, M, Const)
//   out_valid/out_ready/out_data result stream (out_data = 0 on timeout)
//   out_err                  1 = result is a timeout, qualifies out_data
//   busy                     high while running or holding a result
//   core_en                  enable to the core; low resets the core
//   core_P/E/M/Const         operand registers driven to the core
//   core_C, core_eoc         result and end-of-computation from the core
// ---------------------------------------------------------------------------
module rsa_host_initiator #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy,
    output logic             core_en,
    output logic [WIDTH-1:0] core_P,
    output logic [WIDTH-1:0] core_E,
    output logic [WIDTH-1:0] core_M,
    output logic [WIDTH-1:0] core_Const,
    input  logic [WIDTH-1:0] core_C,
    input  logic             core_eoc
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The watchdog only has to count 0 .. TIMEOUT_CYCLES-1.
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_reg;
    logic [1:0]       cnt_reg;
    logic [WD_W-1:0]  wd_reg;
    logic             accept;
    logic [WIDTH-1:0] opnd [4];

    // in_ready is also gated by rst, so it only rises once reset is released.
    assign in_ready = (state_reg == ST_LOAD) && !rst;
    assign busy     = (state_reg == ST_RUN) || (state_reg == ST_DONE);
    assign accept   = (state_reg == ST_LOAD) && in_valid;

    // One operand register per slot. The word counter selects the slot. The
    // registers are written only in LOAD, so they stay frozen while the core
    // runs. They also keep their values after a job finishes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_opnd
        logic [WIDTH-1:0] q_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_reg <= '0;
            end else if (accept && (cnt_reg == 2'(gi))) begin
                q_reg <= in_data;
            end
        end

        assign opnd[gi] = q_reg;
    end

    assign core_P     = opnd[0];
    assign core_E     = opnd[1];
    assign core_M     = opnd[2];
    assign core_Const = opnd[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_LOAD;
            cnt_reg   <= 2'd0;
            wd_reg    <= '0;
            core_en   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (in_valid) begin
                        cnt_reg <= cnt_reg + 2'd1;   // wraps to 0 after Const
                        if (cnt_reg == 2'd3) begin
                            // Start the core on the same edge that takes the
                            // last word, so core_en is high right after it.
                            state_reg <= ST_RUN;
                            core_en   <= 1'b1;
                            wd_reg    <= '0;
                        end
                    end
                end

                ST_RUN: begin
                    // eoc is checked first, so a result that arrives on the
                    // watchdog's last cycle still counts as a success.
                    if (core_eoc) begin
                        out_data  <= core_C;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        core_en   <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (wd_reg == WD_LAST) begin
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        core_en   <= 1'b0;
                        state_reg <= ST_DONE;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end

                ST_DONE: begin
                    // out_data and out_err stay as they are after the
                    // handshake. out_err changes only at the next capture.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= ST_LOAD;
                    end
                end

                default: begin
                    state_reg <= ST_LOAD;
                    cnt_reg   <= 2'd0;
                    core_en   <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_host_initiator.sv
// ---------------------------------------------------------------------------
// tb_rsa_host_initiator
//
// Randomized, scoreboard-checked bench for rsa_host_initiator.
//
// A behavioural core model computes P^E mod M. It asserts eoc a chosen number
// of cycles after en rises and toggles eoc randomly while en is low. Each job
// pushes its expected result onto a scoreboard:
//   - data, error flag, and start-to-result latency;
//   - the expected values come from the job's own operands and the core
//     latency, compared against the timeout.
// A separate monitor pops an entry whenever out_valid rises. It also checks
// that the operands stay frozen while core_en is high.
// ---------------------------------------------------------------------------
module tb_rsa_host_initiator;

    localparam int W = 8;
    localparam int T = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         busy;
    logic         core_en;
    logic [W-1:0] core_P, core_E, core_M, core_Const;
    logic [W-1:0] core_C;
    logic         core_eoc;

    always #5 clk = ~clk;

    rsa_host_initiator #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .busy       (busy),
        .core_en    (core_en),
        .core_P     (core_P),
        .core_E     (core_E),
        .core_M     (core_M),
        .core_Const (core_Const),
        .core_C     (core_C),
        .core_eoc   (core_eoc)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] modexp(input logic [7:0] p, input logic [7:0] e,
                                          input logic [7:0] m);
        int r;
        int b;
        if (m == 0) return 8'd0;
        r = 1 % int'(m);
        b = int'(p) % int'(m);
        for (int i = 0; i < 256; i++) begin
            if (i < int'(e)) r = (r * b) % int'(m);
        end
        return 8'(r);
    endfunction

    // ---------------- core model ----------------
    int   core_lat = 20;
    int   core_cnt = 0;
    logic junk_eoc = 1'b0;

    always @(posedge clk) begin
        if (!core_en) core_cnt <= 0;
        else          core_cnt <= core_cnt + 1;
        junk_eoc <= 1'($urandom_range(0, 1));
    end

    assign core_eoc = core_en ? (core_cnt == core_lat) : junk_eoc;
    assign core_C   = modexp(core_P, core_E, core_M);

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] p, e, m, c;
        logic       err;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   en_rise = 0;
    logic prev_en = 1'b0;
    logic prev_ov = 1'b0;
    exp_t cur;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (core_en && !prev_en) en_rise = cyc;
                if (core_en && sb.size() > 0) begin
                    cur = sb[0];
                    check("operands", {core_P, core_E, core_M, core_Const},
                          {cur.p, cur.e, cur.m, cur.c});
                end
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        $display("result: data=%0d err=%0d latency=%0d (expected data=%0d err=%0d latency=%0d)",
                                 out_data, out_err, cyc - en_rise, cur.data, cur.err, cur.lat);
                        check("out_data", out_data, cur.data);
                        check("out_err", out_err, cur.err);
                        check("latency", cyc - en_rise, cur.lat);
                    end
                end
            end
            prev_en = core_en;
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        int k;
        repeat (gap) tick();
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) check("in_ready_wait", 64'd0, 64'd1);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic load_job(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m,
                            input logic [7:0] c, input int lat, input int gap);
        exp_t x;
        x.p = p; x.e = e; x.m = m; x.c = c;
        x.err  = (lat >= T);
        x.data = x.err ? 8'd0 : modexp(p, e, m);
        x.lat  = x.err ? T : lat + 1;
        core_lat = lat;
        sb.push_back(x);
        send_word(p, gap);
        send_word(e, gap);
        send_word(m, gap);
        send_word(c, gap);
        // The core must start right after the edge that takes the 4th word.
        check("start", {core_en, in_ready, busy}, {1'b1, 1'b0, 1'b1});
    endtask

    task automatic wait_result(input int bp, input bit junk);
        int k;
        logic [7:0] d;
        logic er;
        out_ready = (bp == 0);
        k = 0;
        while (!out_valid && k < 200) begin
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            tick();
            k++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("result_wait", 64'd0, 64'd1);
            return;
        end
        d  = out_data;
        er = out_err;
        check("done_core_en", core_en, 1'b0);
        for (int i = 0; i < bp; i++) begin
            tick();
            check("backpressure_hold", {out_valid, in_ready, core_en, busy, out_err, out_data},
                  {1'b1, 1'b0, 1'b0, 1'b1, er, d});
        end
        out_ready = 1'b1;
        tick();
        check("after_handshake", {out_valid, in_ready, busy, out_err}, {1'b0, 1'b1, 1'b0, er});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("reset_state",
              {out_valid, out_data, out_err, busy, core_en, core_P, core_E, core_M, core_Const}, 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);

        // Basic encrypt with 10 cycles of result backpressure.
        load_job(8'd88, 8'd7, 8'd187, 8'h5a, 20, 0);
        wait_result(10, 1'b0);

        // Timeout: the core never finishes, then a good job clears out_err.
        load_job(8'd3, 8'd5, 8'd7, 8'd1, 1000, 0);
        wait_result(0, 1'b0);
        check("err_sticky_in_load", out_err, 1'b1);
        load_job(8'd88, 8'd7, 8'd187, 8'd0, 20, 0);
        wait_result(0, 1'b0);

        // eoc on the same edge as the watchdog expiry.
        load_job(8'd5, 8'd3, 8'd13, 8'd9, T - 1, 0);
        wait_result(1, 1'b0);

        // Stream gaps, and junk on the input while the core runs.
        load_job(8'd88, 8'd7, 8'd187, 8'd2, 30, 1);
        wait_result(2, 1'b1);

        // Reset in the middle of a run.
        load_job(8'd17, 8'd9, 8'd101, 8'd3, 40, 0);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("reset_mid_run", {core_en, busy, out_valid, core_P, core_E}, 64'd0);
        sb.delete();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("in_ready_after_run_reset", in_ready, 1'b1);
        repeat (30) tick();
        load_job(8'd88, 8'd7, 8'd187, 8'd4, 20, 0);
        wait_result(0, 1'b0);

        // Reset in the middle of a load clears the partial words.
        send_word(8'd55, 0);
        send_word(8'd66, 0);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_load", {core_P, core_E}, 64'd0);
        tick();
        rst = 1'b0;
        load_job(8'd9, 8'd4, 8'd23, 8'd8, 12, 0);
        wait_result(0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            load_job(8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 8'($urandom),
                     $urandom_range(1, 55), $urandom_range(0, 2));
            wait_result($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        check("scoreboard_empty", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
